// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcodes, state encoding and helpers for the execute-stage ALU
package alu_pkg;

  localparam int XLEN    = 32;
  localparam int FN_W    = 4;
  localparam int SHAMT_W = $clog2(XLEN);

  localparam logic [FN_W-1:0] FN_ADD   = 4'd0;
  localparam logic [FN_W-1:0] FN_SUB   = 4'd1;
  localparam logic [FN_W-1:0] FN_AND   = 4'd2;
  localparam logic [FN_W-1:0] FN_OR    = 4'd3;
  localparam logic [FN_W-1:0] FN_XOR   = 4'd4;
  localparam logic [FN_W-1:0] FN_SLT   = 4'd5;
  localparam logic [FN_W-1:0] FN_SLTU  = 4'd6;
  localparam logic [FN_W-1:0] FN_SLL   = 4'd7;
  localparam logic [FN_W-1:0] FN_SRL   = 4'd8;
  localparam logic [FN_W-1:0] FN_SRA   = 4'd9;
  localparam logic [FN_W-1:0] FN_COPYA = 4'd10;
  localparam logic [FN_W-1:0] FN_COPYB = 4'd11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  function automatic logic is_shift(input logic [FN_W-1:0] fn);
    return (fn == FN_SLL) || (fn == FN_SRL) || (fn == FN_SRA);
  endfunction

endpackage

// File: rtl/alu_comb.sv
// rtl/alu_comb.sv - single-cycle combinational RV32I integer ALU, barrel shifts included
module alu_comb
  import alu_pkg::*;
#(
  parameter int XLEN = alu_pkg::XLEN
) (
  input  logic [FN_W-1:0] fn,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] y
);

  localparam int SW = $clog2(XLEN);

  logic [SW-1:0] shamt;
  assign shamt = b[SW-1:0];

  always_comb begin
    y = '0;
    case (fn)
      FN_ADD:   y = a + b;
      FN_SUB:   y = a - b;
      FN_AND:   y = a & b;
      FN_OR:    y = a | b;
      FN_XOR:   y = a ^ b;
      FN_SLT:   y = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      FN_SLTU:  y = {{(XLEN-1){1'b0}}, (a < b)};
      FN_SLL:   y = a << shamt;
      FN_SRL:   y = a >> shamt;
      FN_SRA:   y = $signed(a) >>> shamt;
      FN_COPYA: y = a;
      FN_COPYB: y = b;
      default:  y = '0;
    endcase
  end

endmodule

// File: rtl/alu_exec.sv
// rtl/alu_exec.sv - execute-stage ALU with valid/ready handshakes and a 1-bit-per-cycle shifter
module alu_exec
  import alu_pkg::*;
#(
  parameter int XLEN = alu_pkg::XLEN
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            io_in_valid,
  output logic            io_in_ready,
  input  logic [FN_W-1:0] io_alu_fn,
  input  logic [XLEN-1:0] io_opa,
  input  logic [XLEN-1:0] io_opb,
  output logic            io_out_valid,
  input  logic            io_out_ready,
  output logic [XLEN-1:0] io_result
);

  localparam int SW = $clog2(XLEN);

  state_t          state;
  logic [XLEN-1:0] acc;
  logic [XLEN-1:0] acc_next;
  logic [XLEN-1:0] comb_y;
  logic [SW-1:0]   count;
  logic [SW-1:0]   in_shamt;
  logic [FN_W-1:0] shift_fn;
  logic            accept;

  alu_comb #(.XLEN(XLEN)) u_comb (
    .fn (io_alu_fn),
    .a  (io_opa),
    .b  (io_opb),
    .y  (comb_y)
  );

  assign in_shamt = io_opb[SW-1:0];
  assign accept   = io_in_valid & io_in_ready;

  always_comb begin
    io_in_ready = 1'b0;
    case (state)
      ST_IDLE: io_in_ready = 1'b1;
      ST_DONE: io_in_ready = io_out_ready;
      default: io_in_ready = 1'b0;
    endcase
  end

  always_comb begin
    acc_next = acc;
    case (shift_fn)
      FN_SLL:  acc_next = {acc[XLEN-2:0], 1'b0};
      FN_SRL:  acc_next = {1'b0, acc[XLEN-1:1]};
      FN_SRA:  acc_next = {acc[XLEN-1], acc[XLEN-1:1]};
      default: acc_next = acc;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_IDLE;
      io_out_valid <= 1'b0;
      io_result    <= '0;
      count        <= '0;
      acc          <= '0;
      shift_fn     <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          // DONE with a same-cycle accept is handled exactly like IDLE, giving back-to-back ops
          if (accept) begin
            if (is_shift(io_alu_fn) && (in_shamt != '0)) begin
              state        <= ST_SHIFT;
              acc          <= io_opa;
              count        <= in_shamt;
              shift_fn     <= io_alu_fn;
              io_out_valid <= 1'b0;
            end else begin
              state        <= ST_DONE;
              io_result    <= comb_y;
              io_out_valid <= 1'b1;
            end
          end else if (state == ST_DONE && io_out_ready) begin
            state        <= ST_IDLE;
            io_out_valid <= 1'b0;
          end
        end
        ST_SHIFT: begin
          acc   <= acc_next;
          count <= count - 1'b1;
          if (count == SW'(1)) begin
            state        <= ST_DONE;
            io_result    <= acc_next;
            io_out_valid <= 1'b1;
          end
        end
        default: begin
          state        <= ST_IDLE;
          io_out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec.sv
// tb/tb_alu_exec.sv - directed and random self-checking bench for alu_exec
module tb_alu_exec;
  import alu_pkg::*;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            io_in_valid;
  logic            io_in_ready;
  logic [FN_W-1:0] io_alu_fn;
  logic [31:0]     io_opa;
  logic [31:0]     io_opb;
  logic            io_out_valid;
  logic            io_out_ready;
  logic [31:0]     io_result;

  int n_cmp = 0;
  int n_err = 0;

  alu_exec dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .io_in_valid  (io_in_valid),
    .io_in_ready  (io_in_ready),
    .io_alu_fn    (io_alu_fn),
    .io_opa       (io_opa),
    .io_opb       (io_opb),
    .io_out_valid (io_out_valid),
    .io_out_ready (io_out_ready),
    .io_result    (io_result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [3:0] fn, input logic [31:0] a, input logic [31:0] b);
    case (fn)
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd2:  return a & b;
      4'd3:  return a | b;
      4'd4:  return a ^ b;
      4'd5:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd6:  return (a < b) ? 32'd1 : 32'd0;
      4'd7:  return a << b[4:0];
      4'd8:  return a >> b[4:0];
      4'd9:  return $unsigned($signed(a) >>> b[4:0]);
      4'd10: return a;
      4'd11: return b;
      default: return 32'd0;
    endcase
  endfunction

  // Issue one op from IDLE, drain it with io_out_ready=1, and check latency, busy cycles and result.
  task automatic run_op(input string tag, input logic [3:0] fn, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
    int lat;
    int busy;
    @(negedge clk);
    io_in_valid = 1'b1; io_alu_fn = fn; io_opa = a; io_opb = b; io_out_ready = 1'b1;
    #1;
    chk({tag, "_ready"}, {31'd0, io_in_ready}, 32'd1);
    lat = 0; busy = 0;
    while (1) begin
      @(negedge clk);
      io_in_valid = 1'b0; io_opa = $urandom; io_opb = $urandom; io_alu_fn = 4'($urandom);
      lat++;
      #1;
      if (io_out_valid || lat > 40) break;
      if (!io_in_ready) busy++;
    end
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_busy"}, busy, exp_lat - 1);
    chk({tag, "_res"}, io_result, exp);
    @(negedge clk);
    #1;
    chk({tag, "_drain"}, {31'd0, io_out_valid}, 32'd0);
  endtask

  initial begin
    logic [31:0] q[$];
    logic [31:0] exp_v;
    logic        acc_now;
    logic        take_now;
    int          guard;

    reset_n = 1'b0; io_in_valid = 1'b0; io_out_ready = 1'b0;
    io_alu_fn = '0; io_opa = '0; io_opb = '0;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", {31'd0, io_out_valid}, 32'd0);
    chk("rst_result", io_result, 32'd0);
    chk("rst_in_ready", {31'd0, io_in_ready}, 32'd1);
    reset_n = 1'b1;

    run_op("add",   FN_ADD,   32'd5,        32'd7,        32'h0000000C, 1);
    run_op("sub",   FN_SUB,   32'd0,        32'd1,        32'hFFFFFFFF, 1);
    run_op("slt",   FN_SLT,   32'hFFFFFFFF, 32'd1,        32'd1,        1);
    run_op("sltu",  FN_SLTU,  32'hFFFFFFFF, 32'd1,        32'd0,        1);
    run_op("copya", FN_COPYA, 32'h12345000, 32'h0,        32'h12345000, 1);
    run_op("copyb", FN_COPYB, 32'h1,        32'hCAFEF00D, 32'hCAFEF00D, 1);
    run_op("fn13",  4'd13,    32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0,        1);
    run_op("sra4",  FN_SRA,   32'h80000000, 32'd4,        32'hF8000000, 5);
    run_op("sll0",  FN_SLL,   32'hA5A5A5A5, 32'h20,       32'hA5A5A5A5, 1);
    run_op("sll3",  FN_SLL,   32'h80000011, 32'd3,        32'h00000088, 4);
    run_op("srl31", FN_SRL,   32'h80000000, 32'd31,       32'h00000001, 32);

    // Backpressure: result held while consumer stalls, then take + accept in one cycle.
    @(negedge clk);
    io_in_valid = 1'b1; io_alu_fn = FN_AND; io_opa = 32'h0000F0F0; io_opb = 32'h0000FF00;
    io_out_ready = 1'b0;
    @(negedge clk);
    io_in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_valid", {31'd0, io_out_valid}, 32'd1);
      chk("bp_result", io_result, 32'h0000F000);
      @(negedge clk);
    end
    io_out_ready = 1'b1; io_in_valid = 1'b1; io_alu_fn = FN_XOR;
    io_opa = 32'h000000F0; io_opb = 32'h000000FF;
    #1;
    chk("bp_in_ready", {31'd0, io_in_ready}, 32'd1);
    @(negedge clk);
    io_in_valid = 1'b0; io_out_ready = 1'b0;
    #1;
    chk("b2b_valid", {31'd0, io_out_valid}, 32'd1);
    chk("b2b_result", io_result, 32'h0000000F);
    io_out_ready = 1'b1;
    @(negedge clk);
    #1;
    chk("b2b_drain", {31'd0, io_out_valid}, 32'd0);

    // Reset in the middle of a long shift.
    @(negedge clk);
    io_in_valid = 1'b1; io_alu_fn = FN_SRL; io_opa = 32'hFFFF0000; io_opb = 32'd20;
    @(negedge clk);
    io_in_valid = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    chk("mid_busy", {31'd0, io_in_ready}, 32'd0);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_valid", {31'd0, io_out_valid}, 32'd0);
    chk("mid_rst_ready", {31'd0, io_in_ready}, 32'd1);
    @(negedge clk);
    reset_n = 1'b1;
    guard = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (io_out_valid) guard++;
    end
    chk("mid_no_result", guard, 32'd0);
    run_op("post_add", FN_ADD, 32'h7FFFFFFF, 32'd1, 32'h80000000, 1);

    // Random stream with random backpressure against the reference model.
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(negedge clk);
      io_in_valid  = ($urandom_range(0, 2) != 0);
      io_out_ready = ($urandom_range(0, 3) != 0);
      io_alu_fn    = 4'($urandom);
      io_opa       = $urandom;
      io_opb       = ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 3));
      #1;
      acc_now  = io_in_valid & io_in_ready;
      take_now = io_out_valid & io_out_ready;
      if (take_now) begin
        if (q.size() == 0) chk("rnd_extra_result", io_result, 32'hDEADBEEF ^ io_result ^ 32'h1);
        else begin
          exp_v = q.pop_front();
          chk("rnd_result", io_result, exp_v);
        end
      end
      if (acc_now) q.push_back(model(io_alu_fn, io_opa, io_opb));
    end
    @(negedge clk);
    io_in_valid = 1'b0; io_out_ready = 1'b1;
    guard = 0;
    while (q.size() != 0 && guard < 200) begin
      #1;
      if (io_out_valid) begin
        exp_v = q.pop_front();
        chk("rnd_drain_result", io_result, exp_v);
      end
      @(negedge clk);
      guard++;
    end
    chk("rnd_left_over", q.size(), 32'd0);
    repeat (2) @(negedge clk);
    chk("rnd_final_idle", {31'd0, io_out_valid}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
